branch_predict_unit: RTL and testbench
======================================

# branch_predict_unit

Parametrised successor to the ID-stage branch resolver. It predicts branch direction and target at fetch time from a direct-mapped branch target buffer (BTB) that holds 2-bit saturating counters. At decode it resolves the real outcome, supporting BEQ, BNE, BLEZ, BGTZ, BLTZ, BGEZ, J, JAL, JR and JALR. It flags mispredictions with the redirect PC and trains the BTB on the following clock edge.

## Interface
- OPCODE_BITS, 6, opcode width
- FUNCT_BITS, 6, funct width
- PROC_BITS, 32, data/immediate width
- PC_BITS, 32, PC width (word address)
- BTB_DEPTH, 64, BTB entries; power of two, ≥2
- PERF_BITS, 32, perf counter width (only with the macro)
- i_clock  in  1  sole clock; all state updates on the rising edge
- i_reset  in  1  synchronous, active-high reset
- i_fetch_pc  in  PC_BITS  PC being fetched
- o_pred_taken  out  1  fetch-side prediction (combinational from table state)
- o_pred_target  out  PC_BITS  predicted target; 0 when not predicted taken
- i_resolve_valid  in  1  branch/jump instruction present in ID
- i_resolve_pc  in  PC_BITS  PC of the resolving instruction
- i_pred_taken, i_pred_target  in  1, PC_BITS  prediction carried down the pipe with the instruction
- i_opcode, i_funct  in  OPCODE_BITS, FUNCT_BITS  instruction fields
- i_rt_field  in  5  rt field (REGIMM selector)
- i_pc_next, i_immediate, i_jump_address  in  PC_BITS, PROC_BITS, PROC_BITS  PC+1, sign-extended offset, absolute jump target
- i_data_rs, i_data_rt  in  PROC_BITS  forwarded operands
- o_taken, o_target  out  1, PC_BITS  resolved outcome and target
- o_pc_to_reg, o_pc_reg_sel, o_pc_return  out  1, 1, PC_BITS  link controls; o_pc_return = i_pc_next
- o_mispredict  out  1  prediction wrong; flush IF
- o_redirect_pc  out  PC_BITS  correct next PC when o_mispredict is asserted, else 0
- o_branch_count, o_mispredict_count  out  PERF_BITS  perf counters (only with the macro)

## Operation
- Entry layout: valid, tag = pc[PC_BITS-1:IDX], target, ctr[1:0]. IDX = log2(BTB_DEPTH). Index = pc[IDX-1:0].
- Fetch: hit = valid && tag match. o_pred_taken = hit && ctr[1]. o_pred_target = entry target when predicted taken, else 0.
- Resolve, gated by i_resolve_valid:
  - BEQ/BNE: rs ==/!= rt.
  - BLEZ (000110) / BGTZ (000111): signed rs ≤0 / >0.
  - REGIMM (000001): rt_field 00000 = BLTZ (rs<0), 00001 = BGEZ (rs≥0).
  - Conditional target = i_pc_next + i_immediate, truncated to PC_BITS.
  - J/JAL target = i_jump_address. JR (funct 001000) / JALR (001001) target = i_data_rs.
  - JAL: pc_to_reg=1, pc_reg_sel=1. JALR: pc_to_reg=1, pc_reg_sel=0.
  - Any other encoding, or i_resolve_valid=0: taken, pc_to_reg, pc_reg_sel, target, mispredict all 0.
- o_mispredict = valid branch && (i_pred_taken != o_taken || (o_taken && i_pred_target != o_target)).
- o_redirect_pc = o_taken ? o_target : i_pc_next.
- Training, at the next edge, for recognised branches only:
  - Hit: ctr increments on taken and decrements on not-taken, saturating at 11/00. Target is rewritten on taken.
  - Miss and taken: allocate/overwrite the entry. Conditional branches get ctr=10; unconditional jumps get ctr=11.
  - Miss and not taken: no write.

## Timing
- Prediction: 0-cycle combinational read of registered state.
- Resolve outputs: 0-cycle combinational.
- Table update becomes visible to fetch one cycle after resolve.
- Fetch and update to the same index in the same cycle: fetch sees the old entry (no bypass).
- Reset: all valid bits clear the cycle after i_reset is sampled high. Targets, tags and counters are don't-care. No prediction is made until reallocation.
- Reset asserted together with i_resolve_valid: reset wins and no update is written.
- Combinational outputs follow inputs during reset. With all entries invalid, o_pred_taken=0 and o_pred_target=0.

## Configuration
- BRANCH_PERF_CNT_EN defined:
  - o_branch_count increments per valid recognised branch.
  - o_mispredict_count increments per o_mispredict.
  - Both saturate at all-ones and clear on reset.
- Undefined: the counters, the two ports and PERF_BITS do not exist.

## Structure
- Shared package/constants header holds:
  - opcode localparams (BEQ, BNE, BLEZ, BGTZ, REGIMM, J, JAL, SPECIAL);
  - funct codes (JR, JALR) and REGIMM rt codes (BLTZ, BGEZ);
  - counter encodings (SNT=00, WNT=01, WT=10, ST=11).
- One sub-module: branch_target_buffer.
  - Holds the storage array: one combinational read port, one synchronous write port, and valid-bit reset.
  - Decode, compare, mispredict and training logic stay in the top level.

## Test plan
- Reset, then fetch pc 0x10 -> o_pred_taken=0, o_pred_target=0.
- BEQ at 0x10, rs=rt=5, pc_next=0x11, imm=4, pred 0 -> o_taken=1, target 0x15, o_mispredict=1, redirect 0x15. Next cycle fetch 0x10 -> predicts taken, target 0x15.
- Same BEQ with rs≠rt, three times -> counter 10→01→00. Fetch predicts not taken after the first update. Counter stays saturated at 00.
- BTB_DEPTH=64: JAL at 0x05 then JAL at 0x45 -> second evicts the first. Fetch 0x05 misses. JAL link outputs pc_to_reg=1, pc_reg_sel=1, pc_return=pc_next.
- BLTZ with rs=0xFFFFFFFF -> taken. BGEZ with rs=0 -> taken. BGTZ with rs=0 -> not taken.
- Resolve and fetch of the same index in the same cycle -> fetch sees the old entry. i_reset with a valid resolve -> no allocation. Perf counters (with the macro) read 0 after reset.

Source files
------------

// File: rtl/branch_predict_unit_pkg.sv
// Shared constants for the branch predictor and resolver.
// Contents: instruction field encodings (opcodes, SPECIAL funct codes,
// REGIMM rt selectors), 2-bit saturating counter encodings and the
// counter update helper.
package branch_predict_unit_pkg;

    // Primary opcodes.
    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_REGIMM  = 6'b000001;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [5:0] OP_BLEZ    = 6'b000110;
    localparam logic [5:0] OP_BGTZ    = 6'b000111;

    // SPECIAL funct codes.
    localparam logic [5:0] FN_JR   = 6'b001000;
    localparam logic [5:0] FN_JALR = 6'b001001;

    // REGIMM rt selectors.
    localparam logic [4:0] RT_BLTZ = 5'b00000;
    localparam logic [4:0] RT_BGEZ = 5'b00001;

    typedef logic [1:0] ctr_t;

    // Counter encodings: strongly/weakly not-taken, weakly/strongly taken.
    localparam ctr_t CTR_SNT = 2'b00;
    localparam ctr_t CTR_WNT = 2'b01;
    localparam ctr_t CTR_WT  = 2'b10;
    localparam ctr_t CTR_ST  = 2'b11;

    // Saturating step toward the resolved direction.
    function automatic ctr_t ctr_next(input ctr_t ctr, input logic taken);
        ctr_t res;
        res = ctr;
        if (taken) begin
            if (ctr != CTR_ST) res = ctr + 2'd1;
        end else begin
            if (ctr != CTR_SNT) res = ctr - 2'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer.
// Each entry holds valid, tag (pc[PC_BITS-1:IDX]), target and a 2-bit counter;
// the index is pc[IDX-1:0]. Reads are combinational from registered state,
// so a write is visible to readers from the following cycle only.
// Ports:
//   i_clock, i_reset       clock, synchronous active-high reset (clears valid bits)
//   i_rd_pc                fetch-side read address
//   o_rd_hit/target/ctr    fetch-side entry contents
//   i_lk_pc                training-side lookup address (resolving instruction)
//   o_lk_hit/target/ctr    training-side entry contents
//   i_wr_en/pc/target/ctr  synchronous write; sets valid and tag of the entry
module branch_target_buffer
    import branch_predict_unit_pkg::*;
#(
    parameter int unsigned PC_BITS   = 32,
    parameter int unsigned BTB_DEPTH = 64
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic [PC_BITS-1:0] i_rd_pc,
    output logic               o_rd_hit,
    output logic [PC_BITS-1:0] o_rd_target,
    output logic [1:0]         o_rd_ctr,
    input  logic [PC_BITS-1:0] i_lk_pc,
    output logic               o_lk_hit,
    output logic [PC_BITS-1:0] o_lk_target,
    output logic [1:0]         o_lk_ctr,
    input  logic               i_wr_en,
    input  logic [PC_BITS-1:0] i_wr_pc,
    input  logic [PC_BITS-1:0] i_wr_target,
    input  logic [1:0]         i_wr_ctr
);

    localparam int unsigned IDX_BITS = $clog2(BTB_DEPTH);
    localparam int unsigned TAG_BITS = PC_BITS - IDX_BITS;

    logic [BTB_DEPTH-1:0] valid_q;
    logic [TAG_BITS-1:0]  tag_q    [BTB_DEPTH];
    logic [PC_BITS-1:0]   target_q [BTB_DEPTH];
    ctr_t                 ctr_q    [BTB_DEPTH];

    logic [IDX_BITS-1:0] rd_idx, lk_idx, wr_idx;

    assign rd_idx = i_rd_pc[IDX_BITS-1:0];
    assign lk_idx = i_lk_pc[IDX_BITS-1:0];
    assign wr_idx = i_wr_pc[IDX_BITS-1:0];

    assign o_rd_hit    = valid_q[rd_idx] && (tag_q[rd_idx] == i_rd_pc[PC_BITS-1:IDX_BITS]);
    assign o_rd_target = target_q[rd_idx];
    assign o_rd_ctr    = ctr_q[rd_idx];

    assign o_lk_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == i_lk_pc[PC_BITS-1:IDX_BITS]);
    assign o_lk_target = target_q[lk_idx];
    assign o_lk_ctr    = ctr_q[lk_idx];

    // Only valid bits are reset; the rest of an entry is meaningless until allocated.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            valid_q <= '0;
        end else if (i_wr_en) begin
            valid_q[wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_wr_en && !i_reset) begin
            tag_q[wr_idx]    <= i_wr_pc[PC_BITS-1:IDX_BITS];
            target_q[wr_idx] <= i_wr_target;
            ctr_q[wr_idx]    <= i_wr_ctr;
        end
    end

endmodule

// File: rtl/branch_predict_unit.sv
// Fetch-time branch predictor plus decode-stage branch resolver.
// Predicts direction/target from a direct-mapped BTB, resolves BEQ, BNE, BLEZ,
// BGTZ, BLTZ, BGEZ, J, JAL, JR and JALR, flags mispredictions with a redirect
// PC and trains the BTB on the next clock edge.
// Optional macro BRANCH_PERF_CNT_EN adds saturating branch/mispredict counters
// (parameter PERF_BITS, ports o_branch_count and o_mispredict_count).
// Ports:
//   i_clock, i_reset                   clock, synchronous active-high reset
//   i_fetch_pc                         PC being fetched
//   o_pred_taken, o_pred_target        fetch prediction (target 0 unless taken)
//   i_resolve_valid, i_resolve_pc      branch in decode and its PC
//   i_pred_taken, i_pred_target        prediction that travelled with it
//   i_opcode, i_funct, i_rt_field      instruction fields
//   i_pc_next, i_immediate, i_jump_address  PC+1, offset, absolute target
//   i_data_rs, i_data_rt               forwarded operands
//   o_taken, o_target                  resolved outcome
//   o_pc_to_reg, o_pc_reg_sel, o_pc_return  link controls
//   o_mispredict, o_redirect_pc        flush request and correct next PC
module branch_predict_unit
    import branch_predict_unit_pkg::*;
#(
    parameter int unsigned OPCODE_BITS = 6,
    parameter int unsigned FUNCT_BITS  = 6,
    parameter int unsigned PROC_BITS   = 32,
    parameter int unsigned PC_BITS     = 32,
    parameter int unsigned BTB_DEPTH   = 64
`ifdef BRANCH_PERF_CNT_EN
    ,
    parameter int unsigned PERF_BITS   = 32
`endif
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic [PC_BITS-1:0]     i_fetch_pc,
    output logic                   o_pred_taken,
    output logic [PC_BITS-1:0]     o_pred_target,
    input  logic                   i_resolve_valid,
    input  logic [PC_BITS-1:0]     i_resolve_pc,
    input  logic                   i_pred_taken,
    input  logic [PC_BITS-1:0]     i_pred_target,
    input  logic [OPCODE_BITS-1:0] i_opcode,
    input  logic [FUNCT_BITS-1:0]  i_funct,
    input  logic [4:0]             i_rt_field,
    input  logic [PC_BITS-1:0]     i_pc_next,
    input  logic [PROC_BITS-1:0]   i_immediate,
    input  logic [PROC_BITS-1:0]   i_jump_address,
    input  logic [PROC_BITS-1:0]   i_data_rs,
    input  logic [PROC_BITS-1:0]   i_data_rt,
    output logic                   o_taken,
    output logic [PC_BITS-1:0]     o_target,
    output logic                   o_pc_to_reg,
    output logic                   o_pc_reg_sel,
    output logic [PC_BITS-1:0]     o_pc_return,
    output logic                   o_mispredict,
    output logic [PC_BITS-1:0]     o_redirect_pc
`ifdef BRANCH_PERF_CNT_EN
    ,
    output logic [PERF_BITS-1:0]   o_branch_count,
    output logic [PERF_BITS-1:0]   o_mispredict_count
`endif
);

    localparam int unsigned SUM_BITS = (PC_BITS > PROC_BITS) ? PC_BITS : PROC_BITS;

    // ---------------- BTB ----------------
    logic               fetch_hit;
    logic [PC_BITS-1:0] fetch_target;
    ctr_t               fetch_ctr;
    logic               lk_hit;
    logic [PC_BITS-1:0] lk_target;
    ctr_t               lk_ctr;
    logic               wr_en;
    logic [PC_BITS-1:0] wr_target;
    ctr_t               wr_ctr;

    branch_target_buffer #(
        .PC_BITS  (PC_BITS),
        .BTB_DEPTH(BTB_DEPTH)
    ) u_btb (
        .i_clock    (i_clock),
        .i_reset    (i_reset),
        .i_rd_pc    (i_fetch_pc),
        .o_rd_hit   (fetch_hit),
        .o_rd_target(fetch_target),
        .o_rd_ctr   (fetch_ctr),
        .i_lk_pc    (i_resolve_pc),
        .o_lk_hit   (lk_hit),
        .o_lk_target(lk_target),
        .o_lk_ctr   (lk_ctr),
        .i_wr_en    (wr_en),
        .i_wr_pc    (i_resolve_pc),
        .i_wr_target(wr_target),
        .i_wr_ctr   (wr_ctr)
    );

    // Direction comes from the counter MSB only.
    logic unused_fetch_ctr;
    assign unused_fetch_ctr = fetch_ctr[0];

    assign o_pred_taken  = fetch_hit && fetch_ctr[1];
    assign o_pred_target = o_pred_taken ? fetch_target : '0;

    // ---------------- Resolve ----------------
    logic [SUM_BITS-1:0] cond_sum;
    logic [PC_BITS-1:0]  cond_target;
    logic                rs_neg, rs_zero;
    logic                known;   // recognised branch/jump in a valid slot
    logic                uncond;  // J/JAL/JR/JALR

    assign cond_sum    = SUM_BITS'(i_pc_next) + SUM_BITS'($signed(i_immediate));
    assign cond_target = PC_BITS'(cond_sum);
    assign rs_neg      = i_data_rs[PROC_BITS-1];
    assign rs_zero     = (i_data_rs == '0);

    always_comb begin
        o_taken      = 1'b0;
        o_target     = '0;
        o_pc_to_reg  = 1'b0;
        o_pc_reg_sel = 1'b0;
        known        = 1'b0;
        uncond       = 1'b0;
        if (i_resolve_valid) begin
            case (i_opcode)
                OPCODE_BITS'(OP_BEQ): begin
                    known    = 1'b1;
                    o_taken  = (i_data_rs == i_data_rt);
                    o_target = cond_target;
                end
                OPCODE_BITS'(OP_BNE): begin
                    known    = 1'b1;
                    o_taken  = (i_data_rs != i_data_rt);
                    o_target = cond_target;
                end
                OPCODE_BITS'(OP_BLEZ): begin
                    known    = 1'b1;
                    o_taken  = rs_neg || rs_zero;
                    o_target = cond_target;
                end
                OPCODE_BITS'(OP_BGTZ): begin
                    known    = 1'b1;
                    o_taken  = !rs_neg && !rs_zero;
                    o_target = cond_target;
                end
                OPCODE_BITS'(OP_REGIMM): begin
                    if (i_rt_field == RT_BLTZ) begin
                        known    = 1'b1;
                        o_taken  = rs_neg;
                        o_target = cond_target;
                    end else if (i_rt_field == RT_BGEZ) begin
                        known    = 1'b1;
                        o_taken  = !rs_neg;
                        o_target = cond_target;
                    end
                end
                OPCODE_BITS'(OP_J), OPCODE_BITS'(OP_JAL): begin
                    known    = 1'b1;
                    uncond   = 1'b1;
                    o_taken  = 1'b1;
                    o_target = PC_BITS'(i_jump_address);
                    if (i_opcode == OPCODE_BITS'(OP_JAL)) begin
                        o_pc_to_reg  = 1'b1;
                        o_pc_reg_sel = 1'b1;
                    end
                end
                OPCODE_BITS'(OP_SPECIAL): begin
                    if (i_funct == FUNCT_BITS'(FN_JR) || i_funct == FUNCT_BITS'(FN_JALR)) begin
                        known       = 1'b1;
                        uncond      = 1'b1;
                        o_taken     = 1'b1;
                        o_target    = PC_BITS'(i_data_rs);
                        o_pc_to_reg = (i_funct == FUNCT_BITS'(FN_JALR));
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_pc_return = i_pc_next;

    // A correct direction with a wrong target still needs a redirect.
    assign o_mispredict  = known && ((i_pred_taken != o_taken) ||
                                     (o_taken && (i_pred_target != o_target)));
    assign o_redirect_pc = o_mispredict ? (o_taken ? o_target : i_pc_next) : '0;

    // ---------------- Training ----------------
    // Hits always update the counter; misses allocate only when taken.
    assign wr_en     = known && !i_reset && (lk_hit || o_taken);
    assign wr_ctr    = lk_hit ? ctr_next(lk_ctr, o_taken) : (uncond ? CTR_ST : CTR_WT);
    assign wr_target = o_taken ? o_target : lk_target;

`ifdef BRANCH_PERF_CNT_EN
    logic [PERF_BITS-1:0] branch_cnt_q, branch_cnt_d;
    logic [PERF_BITS-1:0] mispred_cnt_q, mispred_cnt_d;

    always_comb begin
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (known && (branch_cnt_q != '1)) branch_cnt_d = branch_cnt_q + 1'b1;
        if (o_mispredict && (mispred_cnt_q != '1)) mispred_cnt_d = mispred_cnt_q + 1'b1;
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign o_branch_count     = branch_cnt_q;
    assign o_mispredict_count = mispred_cnt_q;
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Self-checking bench for branch_predict_unit (default parameters).
// Table-driven resolve vectors plus hand-written multi-cycle sequences for
// BTB allocation, counter saturation, eviction, same-cycle access and reset.
module tb_branch_predict_unit;

    logic        i_clock = 1'b0;
    logic        i_reset;
    logic [31:0] i_fetch_pc;
    logic        o_pred_taken;
    logic [31:0] o_pred_target;
    logic        i_resolve_valid;
    logic [31:0] i_resolve_pc;
    logic        i_pred_taken;
    logic [31:0] i_pred_target;
    logic [5:0]  i_opcode;
    logic [5:0]  i_funct;
    logic [4:0]  i_rt_field;
    logic [31:0] i_pc_next;
    logic [31:0] i_immediate;
    logic [31:0] i_jump_address;
    logic [31:0] i_data_rs;
    logic [31:0] i_data_rt;
    logic        o_taken;
    logic [31:0] o_target;
    logic        o_pc_to_reg;
    logic        o_pc_reg_sel;
    logic [31:0] o_pc_return;
    logic        o_mispredict;
    logic [31:0] o_redirect_pc;
`ifdef BRANCH_PERF_CNT_EN
    logic [31:0] o_branch_count;
    logic [31:0] o_mispredict_count;
`endif

    always #5 i_clock = ~i_clock;

    branch_predict_unit dut (
        .i_clock        (i_clock),
        .i_reset        (i_reset),
        .i_fetch_pc     (i_fetch_pc),
        .o_pred_taken   (o_pred_taken),
        .o_pred_target  (o_pred_target),
        .i_resolve_valid(i_resolve_valid),
        .i_resolve_pc   (i_resolve_pc),
        .i_pred_taken   (i_pred_taken),
        .i_pred_target  (i_pred_target),
        .i_opcode       (i_opcode),
        .i_funct        (i_funct),
        .i_rt_field     (i_rt_field),
        .i_pc_next      (i_pc_next),
        .i_immediate    (i_immediate),
        .i_jump_address (i_jump_address),
        .i_data_rs      (i_data_rs),
        .i_data_rt      (i_data_rt),
        .o_taken        (o_taken),
        .o_target       (o_target),
        .o_pc_to_reg    (o_pc_to_reg),
        .o_pc_reg_sel   (o_pc_reg_sel),
        .o_pc_return    (o_pc_return),
        .o_mispredict   (o_mispredict),
        .o_redirect_pc  (o_redirect_pc)
`ifdef BRANCH_PERF_CNT_EN
        ,
        .o_branch_count    (o_branch_count),
        .o_mispredict_count(o_mispredict_count)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clock);
        #1;
    endtask

    task automatic chk_fetch(input string name, input logic [31:0] pc,
                             input logic exp_tk, input logic [31:0] exp_tg);
        i_fetch_pc = pc;
        #1;
        check({name, "_pred_taken"}, 64'(o_pred_taken), 64'(exp_tk));
        check({name, "_pred_target"}, 64'(o_pred_target), 64'(exp_tg));
    endtask

    task automatic resolve(input logic [31:0] pc, input logic [5:0] op, input logic [5:0] fn,
                           input logic [4:0] rt, input logic [31:0] rs, input logic [31:0] rtd,
                           input logic [31:0] pcn, input logic [31:0] imm,
                           input logic [31:0] ja, input logic pt, input logic [31:0] ptg);
        i_resolve_valid = 1'b1;
        i_resolve_pc    = pc;
        i_opcode        = op;
        i_funct         = fn;
        i_rt_field      = rt;
        i_data_rs       = rs;
        i_data_rt       = rtd;
        i_pc_next       = pcn;
        i_immediate     = imm;
        i_jump_address  = ja;
        i_pred_taken    = pt;
        i_pred_target   = ptg;
        #1;
    endtask

    typedef struct {
        logic        vld;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [4:0]  rt;
        logic [31:0] rs;
        logic [31:0] rtd;
        logic [31:0] pcn;
        logic [31:0] imm;
        logic [31:0] ja;
        logic        pt;
        logic [31:0] ptg;
        logic        tk;
        logic        chk_tg;
        logic [31:0] tg;
        logic        ptr;
        logic        sel;
        logic        mp;
        logic [31:0] rd;
    } vec_t;

    localparam int NV = 19;
    vec_t vecs [NV];

    initial begin
        //          vld op    fn     rt rs            rtd pcn    imm           ja       pt ptg      tk ct tg       ptr sel mp rd
        vecs[0]  = '{1, 6'h04, 6'h00, 0, 7,            7, 'h101, 'hFFFFFFFE,  0,       1, 'hFF,    1, 1, 'hFF,    0, 0, 0, 0};
        vecs[1]  = '{1, 6'h05, 6'h00, 0, 1,            2, 'h41,  3,           0,       1, 'h50,    1, 1, 'h44,    0, 0, 1, 'h44};
        vecs[2]  = '{1, 6'h05, 6'h00, 0, 9,            9, 'h51,  3,           0,       0, 0,       0, 0, 0,       0, 0, 0, 0};
        vecs[3]  = '{1, 6'h06, 6'h00, 0, 0,            0, 'h61,  'h10,        0,       0, 0,       1, 1, 'h71,    0, 0, 1, 'h71};
        vecs[4]  = '{1, 6'h06, 6'h00, 0, 5,            0, 'h69,  'h10,        0,       1, 'h79,    0, 0, 0,       0, 0, 1, 'h69};
        vecs[5]  = '{1, 6'h07, 6'h00, 0, 0,            0, 'h71,  4,           0,       0, 0,       0, 0, 0,       0, 0, 0, 0};
        vecs[6]  = '{1, 6'h07, 6'h00, 0, 1,            0, 'h81,  7,           0,       1, 'h88,    1, 1, 'h88,    0, 0, 0, 0};
        vecs[7]  = '{1, 6'h01, 6'h00, 0, 'hFFFFFFFF,   0, 'h91,  2,           0,       0, 0,       1, 1, 'h93,    0, 0, 1, 'h93};
        vecs[8]  = '{1, 6'h01, 6'h00, 0, 0,            0, 'h95,  2,           0,       0, 0,       0, 0, 0,       0, 0, 0, 0};
        vecs[9]  = '{1, 6'h01, 6'h00, 1, 0,            0, 'hA1,  'hFFFFFFF0,  0,       1, 'h91,    1, 1, 'h91,    0, 0, 0, 0};
        vecs[10] = '{1, 6'h01, 6'h00, 1, 'h80000000,   0, 'hB1,  2,           0,       1, 'h5,     0, 0, 0,       0, 0, 1, 'hB1};
        vecs[11] = '{1, 6'h01, 6'h00, 2, 0,            0, 'hB5,  2,           0,       1, 'h5,     0, 1, 0,       0, 0, 0, 0};
        vecs[12] = '{1, 6'h02, 6'h00, 0, 0,            0, 'hC1,  0,           'h1234,  0, 0,       1, 1, 'h1234,  0, 0, 1, 'h1234};
        vecs[13] = '{1, 6'h03, 6'h00, 0, 0,            0, 'hD1,  0,           'h2000,  1, 'h2000,  1, 1, 'h2000,  1, 1, 0, 0};
        vecs[14] = '{1, 6'h00, 6'h08, 0, 'h777,        0, 'hE1,  0,           0,       1, 'h776,   1, 1, 'h777,   0, 0, 1, 'h777};
        vecs[15] = '{1, 6'h00, 6'h09, 0, 'h888,        0, 'hE5,  0,           0,       1, 'h888,   1, 1, 'h888,   1, 0, 0, 0};
        vecs[16] = '{1, 6'h00, 6'h20, 0, 3,            3, 'hF1,  0,           0,       1, 'h5,     0, 1, 0,       0, 0, 0, 0};
        vecs[17] = '{1, 6'h08, 6'h00, 0, 3,            3, 'hF5,  0,           0,       1, 'h5,     0, 1, 0,       0, 0, 0, 0};
        vecs[18] = '{0, 6'h04, 6'h00, 0, 3,            3, 'hF9,  1,           0,       1, 'hFA,    0, 1, 0,       0, 0, 0, 0};

        i_reset         = 1'b1;
        i_fetch_pc      = '0;
        i_resolve_valid = 1'b0;
        i_resolve_pc    = '0;
        i_pred_taken    = 1'b0;
        i_pred_target   = '0;
        i_opcode        = '0;
        i_funct         = '0;
        i_rt_field      = '0;
        i_pc_next       = '0;
        i_immediate     = '0;
        i_jump_address  = '0;
        i_data_rs       = '0;
        i_data_rt       = '0;
        tick();
        tick();
        i_reset = 1'b0;

        // Reset state.
        chk_fetch("reset_fetch", 32'h10, 1'b0, 32'h0);
`ifdef BRANCH_PERF_CNT_EN
        check("reset_branch_count", 64'(o_branch_count), 64'd0);
        check("reset_mispredict_count", 64'(o_mispredict_count), 64'd0);
`endif

        // Combinational resolve vectors; PCs map to indices 40..58.
        i_fetch_pc = 32'h10;
        for (int i = 0; i < NV; i++) begin
            resolve(32'h1028 + 32'(i), vecs[i].op, vecs[i].fn, vecs[i].rt, vecs[i].rs,
                    vecs[i].rtd, vecs[i].pcn, vecs[i].imm, vecs[i].ja, vecs[i].pt,
                    vecs[i].ptg);
            i_resolve_valid = vecs[i].vld;
            #1;
            check($sformatf("vec%0d_taken", i), 64'(o_taken), 64'(vecs[i].tk));
            if (vecs[i].chk_tg)
                check($sformatf("vec%0d_target", i), 64'(o_target), 64'(vecs[i].tg));
            check($sformatf("vec%0d_pc_to_reg", i), 64'(o_pc_to_reg), 64'(vecs[i].ptr));
            check($sformatf("vec%0d_pc_reg_sel", i), 64'(o_pc_reg_sel), 64'(vecs[i].sel));
            check($sformatf("vec%0d_mispredict", i), 64'(o_mispredict), 64'(vecs[i].mp));
            check($sformatf("vec%0d_redirect", i), 64'(o_redirect_pc), 64'(vecs[i].rd));
            check($sformatf("vec%0d_pc_return", i), 64'(o_pc_return), 64'(vecs[i].pcn));
            tick();
        end
        i_resolve_valid = 1'b0;
        tick();

        // BEQ taken at 0x10 allocates ctr=WT, target 0x15; same-cycle fetch sees the old (empty) entry.
        resolve(32'h10, 6'h04, 6'h00, 5'd0, 32'd5, 32'd5, 32'h11, 32'd4, 32'd0, 1'b0, 32'd0);
        check("beq_alloc_taken", 64'(o_taken), 64'd1);
        check("beq_alloc_target", 64'(o_target), 64'h15);
        check("beq_alloc_mispredict", 64'(o_mispredict), 64'd1);
        check("beq_alloc_redirect", 64'(o_redirect_pc), 64'h15);
        chk_fetch("beq_alloc_same_cycle", 32'h10, 1'b0, 32'h0);
        tick();
        i_resolve_valid = 1'b0;
        chk_fetch("beq_alloc_next", 32'h10, 1'b1, 32'h15);

        // Not-taken three times: 10 -> 01 -> 00 -> 00. Same-cycle fetch still sees 10.
        resolve(32'h10, 6'h04, 6'h00, 5'd0, 32'd5, 32'd6, 32'h11, 32'd4, 32'd0, 1'b1, 32'h15);
        check("beq_nt1_mispredict", 64'(o_mispredict), 64'd1);
        check("beq_nt1_redirect", 64'(o_redirect_pc), 64'h11);
        chk_fetch("beq_nt1_same_cycle", 32'h10, 1'b1, 32'h15);
        tick();
        i_resolve_valid = 1'b0;
        chk_fetch("beq_nt1_after", 32'h10, 1'b0, 32'h0);
        resolve(32'h10, 6'h04, 6'h00, 5'd0, 32'd5, 32'd6, 32'h11, 32'd4, 32'd0, 1'b0, 32'd0);
        check("beq_nt2_mispredict", 64'(o_mispredict), 64'd0);
        tick();
        resolve(32'h10, 6'h04, 6'h00, 5'd0, 32'd5, 32'd6, 32'h11, 32'd4, 32'd0, 1'b0, 32'd0);
        tick();
        i_resolve_valid = 1'b0;
        chk_fetch("beq_nt3_sat", 32'h10, 1'b0, 32'h0);
        // Taken twice from 00: 01 (still not taken), then 10 with a rewritten target.
        resolve(32'h10, 6'h04, 6'h00, 5'd0, 32'd5, 32'd5, 32'h11, 32'd4, 32'd0, 1'b0, 32'd0);
        tick();
        i_resolve_valid = 1'b0;
        chk_fetch("beq_t1_from_sat", 32'h10, 1'b0, 32'h0);
        resolve(32'h10, 6'h04, 6'h00, 5'd0, 32'd5, 32'd5, 32'h11, 32'd5, 32'd0, 1'b0, 32'd0);
        tick();
        i_resolve_valid = 1'b0;
        chk_fetch("beq_t2_retarget", 32'h10, 1'b1, 32'h16);

        // JAL at 0x05 then 0x45: same index, second evicts the first.
        resolve(32'h05, 6'h03, 6'h00, 5'd0, 32'd0, 32'd0, 32'h06, 32'd0, 32'h100, 1'b0, 32'd0);
        check("jal_pc_to_reg", 64'(o_pc_to_reg), 64'd1);
        check("jal_pc_reg_sel", 64'(o_pc_reg_sel), 64'd1);
        check("jal_pc_return", 64'(o_pc_return), 64'h06);
        tick();
        i_resolve_valid = 1'b0;
        chk_fetch("jal_first_alloc", 32'h05, 1'b1, 32'h100);
        resolve(32'h45, 6'h03, 6'h00, 5'd0, 32'd0, 32'd0, 32'h46, 32'd0, 32'h200, 1'b0, 32'd0);
        tick();
        i_resolve_valid = 1'b0;
        chk_fetch("jal_evicted", 32'h05, 1'b0, 32'h0);
        chk_fetch("jal_second", 32'h45, 1'b1, 32'h200);

        // Reset with a valid taken resolve: outputs follow inputs, no allocation.
        i_reset = 1'b1;
        resolve(32'h20, 6'h04, 6'h00, 5'd0, 32'd3, 32'd3, 32'h21, 32'd1, 32'd0, 1'b0, 32'd0);
        check("reset_resolve_taken", 64'(o_taken), 64'd1);
        tick();
        i_reset         = 1'b0;
        i_resolve_valid = 1'b0;
        chk_fetch("reset_no_alloc", 32'h20, 1'b0, 32'h0);
        chk_fetch("reset_cleared", 32'h45, 1'b0, 32'h0);
`ifdef BRANCH_PERF_CNT_EN
        check("reset2_branch_count", 64'(o_branch_count), 64'd0);
        check("reset2_mispredict_count", 64'(o_mispredict_count), 64'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
